// File: rtl/led_frame_receiver.sv
// Receiver for a 595-style serial LED display bus: synchronizes sclk/rclk/dio,
// assembles 16-bit frames and latches segment bytes into an 8-digit register.
module led_frame_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        rclk,
  input  logic        dio,
  output logic [63:0] digit_seg,
  output logic [31:0] digit_num,
  output logic        frame_valid,
  output logic [2:0]  frame_digit,
  output logic        short_err,
  output logic        sel_err,
  output logic        timeout_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  // Bus bits are packed {dio, rclk, sclk} through every synchronizer stage.
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [2:0]  prev_q, prev_d;
  logic [1:0]  rise_q, rise_d;
  state_t      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [63:0] digit_seg_q, digit_seg_d;
  logic [31:0] digit_num_q, digit_num_d;
  logic [2:0]  frame_digit_q, frame_digit_d;
  logic        frame_valid_q, frame_valid_d;
  logic        short_err_q, short_err_d;
  logic        sel_err_q, sel_err_d;
  logic        timeout_err_q, timeout_err_d;

  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   seg_decode = 4'h0;
      7'h79:   seg_decode = 4'h1;
      7'h24:   seg_decode = 4'h2;
      7'h30:   seg_decode = 4'h3;
      7'h19:   seg_decode = 4'h4;
      7'h12:   seg_decode = 4'h5;
      7'h02:   seg_decode = 4'h6;
      7'h78:   seg_decode = 4'h7;
      7'h00:   seg_decode = 4'h8;
      7'h10:   seg_decode = 4'h9;
      7'h7F:   seg_decode = 4'hE;
      default: seg_decode = 4'hF;
    endcase
  endfunction

  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], {dio, rclk, sclk}};
    prev_d        = sync_q[SYNC_STAGES-1];
    rise_d        = sync_q[SYNC_STAGES-1][1:0] & ~prev_q[1:0];
    state_d       = state_q;
    sr_d          = sr_q;
    bit_cnt_d     = bit_cnt_q;
    to_cnt_d      = to_cnt_q;
    digit_seg_d   = digit_seg_q;
    digit_num_d   = digit_num_q;
    frame_digit_d = frame_digit_q;
    frame_valid_d = 1'b0;
    short_err_d   = 1'b0;
    sel_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    // prev_q[2] is the dio sample aligned with the registered sclk rise.
    if (rise_q[0]) begin
      sr_d = {sr_q[14:0], prev_q[2]};
      if (bit_cnt_q != 5'd16) bit_cnt_d = bit_cnt_q + 5'd1;
      to_cnt_d = '0;
      state_d  = (bit_cnt_d == 5'd16) ? FULL : SHIFT;
    end else if (state_q == SHIFT) begin
      if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
        timeout_err_d = 1'b1;
        bit_cnt_d     = '0;
        to_cnt_d      = '0;
        state_d       = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    // Latch evaluates the post-shift register so a coincident last bit counts.
    if (rise_q[1]) begin
      timeout_err_d = 1'b0;
      if (bit_cnt_d != 5'd16) begin
        short_err_d = 1'b1;
      end else if (sr_d[7:0] == 8'h00) begin
        frame_valid_d = 1'b0;
      end else if ($onehot(sr_d[7:0])) begin
        frame_valid_d = 1'b1;
        for (int k = 0; k < 8; k++) begin
          if (sr_d[k]) begin
            digit_seg_d[8*k +: 8] = sr_d[15:8];
            digit_num_d[4*k +: 4] = seg_decode(sr_d[14:8]);
            frame_digit_d         = 3'(k);
          end
        end
      end else begin
        sel_err_d = 1'b1;
      end
      bit_cnt_d = '0;
      to_cnt_d  = '0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      prev_q        <= '0;
      rise_q        <= '0;
      state_q       <= IDLE;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      to_cnt_q      <= '0;
      digit_seg_q   <= {8{8'hFF}};
      digit_num_q   <= {8{4'hE}};
      frame_digit_q <= '0;
      frame_valid_q <= 1'b0;
      short_err_q   <= 1'b0;
      sel_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      rise_q        <= rise_d;
      state_q       <= state_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      to_cnt_q      <= to_cnt_d;
      digit_seg_q   <= digit_seg_d;
      digit_num_q   <= digit_num_d;
      frame_digit_q <= frame_digit_d;
      frame_valid_q <= frame_valid_d;
      short_err_q   <= short_err_d;
      sel_err_q     <= sel_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign digit_seg   = digit_seg_q;
  assign digit_num   = digit_num_q;
  assign frame_digit = frame_digit_q;
  assign frame_valid = frame_valid_q;
  assign short_err   = short_err_q;
  assign sel_err     = sel_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_led_frame_receiver.sv
// Scoreboard bench for led_frame_receiver: directed frames push expected pulses,
// a negedge monitor pops and compares whenever the DUT raises any pulse.
module tb_led_frame_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        rclk = 1'b0;
  logic        dio = 1'b0;
  logic [63:0] digit_seg;
  logic [31:0] digit_num;
  logic        frame_valid;
  logic [2:0]  frame_digit;
  logic        short_err;
  logic        sel_err;
  logic        timeout_err;

  led_frame_receiver #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .rclk(rclk), .dio(dio),
    .digit_seg(digit_seg), .digit_num(digit_num), .frame_valid(frame_valid),
    .frame_digit(frame_digit), .short_err(short_err), .sel_err(sel_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // kind bits: {timeout_err, sel_err, short_err, frame_valid}
  typedef struct packed {
    logic [3:0]  kind;
    logic [2:0]  digit;
    logic [63:0] seg;
    logic [31:0] num;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] exp_seg = {8{8'hFF}};
  logic [31:0] exp_num = {8{4'hE}};
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_commit(input int k, input logic [7:0] seg, input logic [3:0] num);
    exp_t e;
    exp_seg[8*k +: 8] = seg;
    exp_num[4*k +: 4] = num;
    e.kind = 4'b0001; e.digit = 3'(k); e.seg = exp_seg; e.num = exp_num;
    sb.push_back(e);
  endtask

  task automatic expect_pulse(input logic [3:0] kind);
    exp_t e;
    e.kind = kind; e.digit = '0; e.seg = exp_seg; e.num = exp_num;
    sb.push_back(e);
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      dio = v[i];
      #20 sclk = 1'b1;
      #40 sclk = 1'b0;
      #20;
    end
  endtask

  task automatic pulse_rclk();
    rclk = 1'b1;
    #40 rclk = 1'b0;
    #100;
  endtask

  task automatic frame(input logic [15:0] v);
    shift_bits(32'(v), 16);
    pulse_rclk();
  endtask

  always @(negedge clk) begin
    if (!rst && (frame_valid || short_err || sel_err || timeout_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'({timeout_err, sel_err, short_err, frame_valid}), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", 64'({timeout_err, sel_err, short_err, frame_valid}), 64'(e.kind));
        chk("digit_seg", digit_seg, e.seg);
        chk("digit_num", 64'(digit_num), 64'(e.num));
        if (e.kind[0]) chk("frame_digit", 64'(frame_digit), 64'(e.digit));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_seg", digit_seg, {8{8'hFF}});
    chk("rst_num", 64'(digit_num), 64'({8{4'hE}}));
    chk("rst_digit", 64'(frame_digit), 64'd0);
    chk("rst_pulses", 64'({timeout_err, sel_err, short_err, frame_valid}), 64'd0);

    expect_commit(2, 8'hF9, 4'h1);  frame(16'hF904);
    expect_commit(7, 8'h92, 4'h5);  frame(16'h9280);
    expect_commit(0, 8'hC0, 4'h0);  frame(16'hC001);

    expect_pulse(4'b0100);          frame(16'hA406);
    chk("sel_err_seg_kept", digit_seg, exp_seg);
    chk("sel_err_num_kept", 64'(digit_num), 64'(exp_num));
    frame(16'hA400);

    expect_pulse(4'b0010);
    shift_bits(32'h2AB, 10);
    pulse_rclk();
    expect_pulse(4'b1000);
    shift_bits(32'h55, 7);
    repeat (TIMEOUT + 5) @(negedge clk);
    expect_commit(4, 8'hB0, 4'h3);  frame(16'hB010);

    expect_commit(3, 8'h99, 4'h4);
    shift_bits(32'hA9908, 20);
    pulse_rclk();
    expect_commit(3, 8'h12, 4'h5);  frame(16'h1208);
    expect_commit(3, 8'hAA, 4'hF);  frame(16'hAA08);

    // A full frame may sit indefinitely before its latch.
    expect_commit(6, 8'h90, 4'h9);
    shift_bits(32'h9040, 16);
    repeat (TIMEOUT + 20) @(negedge clk);
    pulse_rclk();

    // Last sclk and rclk rise together.
    expect_commit(1, 8'h82, 4'h6);
    shift_bits(32'h4101, 15);
    dio = 1'b0;
    #20 sclk = 1'b1; rclk = 1'b1;
    #40 sclk = 1'b0; rclk = 1'b0;
    #100;

    shift_bits(32'hC0, 8);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    exp_seg = {8{8'hFF}};
    exp_num = {8{4'hE}};
    chk("midrst_seg", digit_seg, exp_seg);
    chk("midrst_num", 64'(digit_num), 64'(exp_num));
    chk("midrst_digit", 64'(frame_digit), 64'd0);
    expect_pulse(4'b0010);
    pulse_rclk();

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
